// File: rtl/tdm_demux.sv
// Receive side of the TDM sample link: tracks channel index from in_sof, stages a frame,
// then publishes all channels together with a one-cycle frame_valid (frame_err on early sof).
module tdm_demux #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   localparam int SELW     = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic                      in_sof,
   input  logic [WIDTH-1:0]          in_data,
   output logic [CHANNELS*WIDTH-1:0] ch_out,
   output logic                      frame_valid,
   output logic                      frame_err,
   output logic                      in_sync,
   output logic [SELW-1:0]           cur_chan
);

   typedef enum logic {IDLE, COLLECT} state_t;

   localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

   state_t                             state_q;
   logic [SELW-1:0]                    cur_q;
   logic [CHANNELS-1:0][WIDTH-1:0]     staging_q;
   logic [CHANNELS-1:0][WIDTH-1:0]     ch_out_q;
   logic                               frame_valid_q;
   logic                               frame_err_q;
   logic [CHANNELS-1:0][WIDTH-1:0]     frame_d;

   // Completed frame: staged channels with the final sample dropped into the top slot.
   always_comb begin
      frame_d       = staging_q;
      frame_d[LAST] = in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cur_q         <= '0;
         staging_q     <= '0;
         ch_out_q      <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         if (in_valid) begin
            case (state_q)
               IDLE: begin
                  if (in_sof) begin
                     staging_q    <= '0;
                     staging_q[0] <= in_data;
                     cur_q        <= SELW'(1);
                     state_q      <= COLLECT;
                  end
               end
               COLLECT: begin
                  if (in_sof) begin
                     // Early sof: abandon the partial frame and resync on the new one.
                     frame_err_q  <= 1'b1;
                     staging_q    <= '0;
                     staging_q[0] <= in_data;
                     cur_q        <= SELW'(1);
                  end else if (cur_q == LAST) begin
                     ch_out_q      <= frame_d;
                     frame_valid_q <= 1'b1;
                     cur_q         <= '0;
                     state_q       <= IDLE;
                  end else begin
                     staging_q[cur_q] <= in_data;
                     cur_q            <= cur_q + 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cur_q   <= '0;
               end
            endcase
         end
      end
   end

   assign ch_out      = ch_out_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign in_sync     = (state_q == COLLECT);
   assign cur_chan    = cur_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (WIDTH=8, CHANNELS=4); expected frames/errors queued by stimulus, checked by a monitor.
module tb_tdm_demux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic [7:0]  in_data = '0;
   logic [31:0] ch_out;
   logic        frame_valid;
   logic        frame_err;
   logic        in_sync;
   logic [1:0]  cur_chan;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_frames[$];
   int          exp_errs = 0;

   tdm_demux #(.WIDTH(8), .CHANNELS(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .ch_out(ch_out), .frame_valid(frame_valid), .frame_err(frame_err),
      .in_sync(in_sync), .cur_chan(cur_chan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic send(input logic sof, input logic [7:0] d);
      in_valid = 1'b1;
      in_sof   = sof;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_valid || frame_err)
            chk("fv_err_exclusive", 64'(frame_valid & frame_err), 64'd0);
         if (frame_valid) begin
            if (exp_frames.size() == 0) chk("unexpected_frame_valid", 64'(ch_out), 64'hDEAD);
            else chk("ch_out", 64'(ch_out), 64'(exp_frames.pop_front()));
         end
         if (frame_err) begin
            if (exp_errs == 0) chk("unexpected_frame_err", 64'd1, 64'd0);
            else begin
               chk("frame_err", 64'd1, 64'd1 & 64'(frame_err));
               exp_errs--;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_ch_out", 64'(ch_out), 64'd0);
      chk("rst_flags", 64'({frame_valid, frame_err, in_sync}), 64'd0);
      chk("rst_cur_chan", 64'(cur_chan), 64'd0);
      rst_n = 1'b1;
      idle(2);

      // 1: reset mid-frame discards partial frame
      send(1'b1, 8'h11);
      send(1'b0, 8'h22);
      chk("t1_in_sync", 64'(in_sync), 64'd1);
      chk("t1_cur_chan", 64'(cur_chan), 64'd2);
      rst_n = 1'b0;
      #1;
      chk("t1_async_rst", 64'({ch_out, frame_valid, frame_err, in_sync, cur_chan}), 64'd0);
      #1 rst_n = 1'b1;
      idle(1);
      send(1'b1, 8'h11); send(1'b0, 8'h22); send(1'b0, 8'h33);
      exp_frames.push_back(32'h44332211);
      send(1'b0, 8'h44);
      idle(2);

      // 2: back-to-back frame
      send(1'b1, 8'hA0); send(1'b0, 8'hA1); send(1'b0, 8'hA2);
      exp_frames.push_back(32'hA3A2A1A0);
      send(1'b0, 8'hA3);
      chk("t2_frame_valid", 64'(frame_valid), 64'd1);
      chk("t2_in_sync", 64'(in_sync), 64'd0);
      chk("t2_cur_chan", 64'(cur_chan), 64'd0);
      idle(1);
      chk("t2_pulse_1cyc", 64'(frame_valid), 64'd0);
      chk("t2_ch_out_hold", 64'(ch_out), 64'hA3A2A1A0);

      // 3: gaps inside the frame
      send(1'b1, 8'hA0); send(1'b0, 8'hA1); idle(1);
      send(1'b0, 8'hA2); idle(2);
      exp_frames.push_back(32'hA3A2A1A0);
      idle(3);
      chk("t3_no_early_valid", 64'(frame_valid), 64'd0);
      send(1'b0, 8'hA3);
      idle(2);

      // 4: hunting drops non-sof samples
      send(1'b0, 8'h55); send(1'b0, 8'h66);
      chk("t4_hunt_sync", 64'({in_sync, cur_chan}), 64'd0);
      send(1'b1, 8'h01); send(1'b0, 8'h02); send(1'b0, 8'h03);
      exp_frames.push_back(32'h04030201);
      send(1'b0, 8'h04);
      idle(2);

      // 5: short frame aborted by early sof
      send(1'b1, 8'h10); send(1'b0, 8'h11);
      exp_errs++;
      send(1'b1, 8'h20);
      chk("t5_resync_chan", 64'(cur_chan), 64'd1);
      chk("t5_in_sync", 64'(in_sync), 64'd1);
      send(1'b0, 8'h21); send(1'b0, 8'h22);
      exp_frames.push_back(32'h23222120);
      send(1'b0, 8'h23);
      idle(2);

      // 6: two frames in 8 consecutive valid cycles
      send(1'b1, 8'hB0); send(1'b0, 8'hB1); send(1'b0, 8'hB2);
      exp_frames.push_back(32'hB3B2B1B0);
      send(1'b0, 8'hB3);
      chk("t6_fv1", 64'(frame_valid), 64'd1);
      send(1'b1, 8'hC0);
      chk("t6_hold_a", 64'({frame_valid, ch_out}), 64'h0B3B2B1B0);
      send(1'b0, 8'hC1);
      send(1'b0, 8'hC2);
      chk("t6_hold_b", 64'({frame_valid, ch_out}), 64'h0B3B2B1B0);
      exp_frames.push_back(32'hC3C2C1C0);
      send(1'b0, 8'hC3);
      chk("t6_fv2", 64'(frame_valid), 64'd1);
      idle(3);

      chk("sb_frames_drained", 64'(exp_frames.size()), 64'd0);
      chk("sb_errs_drained", 64'(exp_errs), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
